// File: rtl/hififo_pkg.sv
// Shared types and constants for the hififo TX arbitration path.
// Imported by the arbiter top and its round-robin picker.
package hififo_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int W_DEF = 64;
  localparam int N_MAX = 8;
  localparam int CNT_W = 32;

  // (base + off) mod n for small non-negative operands
  function automatic int ring_add(
    input int base,
    input int off,
    input int n
  );
    int s;
    s = base + off;
    while (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/hififo_rr_pick.sv
// Combinational one-hot picker: round-robin from a pointer or fixed
// lowest-index priority. Shared by TX arbiter and future RX/irq arbiters.
module hififo_rr_pick
  import hififo_pkg::*;
#(
  parameter int N          = 4,
  parameter int FIXED_PRIO = 0,
  parameter int IW         = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (FIXED_PRIO != 0) ? k : ring_add(int'(ptr), k, N);
      if (!any && req[c]) begin
        win[c] = 1'b1;
        idx    = c[IW-1:0];
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hififo_tx_arb.sv
// N-channel packet arbiter merging TLP sources into the core TX stream.
// Whole packets granted atomically; one registered output stage.
module hififo_tx_arb
  import hififo_pkg::*;
#(
  parameter int N          = 4,
  parameter int W          = W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N-1:0]     in_tvalid,
  input  logic [N*W-1:0]   in_tdata,
  input  logic [N-1:0]     in_tlast,
  input  logic [N-1:0]     in_1dw,
  output logic [N-1:0]     in_tready,
  output logic             tx_tvalid,
  output logic [W-1:0]     tx_tdata,
  output logic             tx_tlast,
  output logic             tx_1dw,
  input  logic             tx_tready,
  output logic [N-1:0]     grant,
  output logic [CNT_W-1:0] pkt_count
);

  localparam int IW = $clog2(N);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] gidx;

  logic [N-1:0]  win;
  logic [IW-1:0] win_idx;
  logic          any_req;

  logic          sel_valid;
  logic          sel_last;
  logic          sel_1dw;
  logic [W-1:0]  sel_data;

  logic          busy;
  logic          can_load;
  logic          acc;

  hififo_rr_pick #(
    .N          (N),
    .FIXED_PRIO (FIXED_PRIO),
    .IW         (IW)
  ) u_pick (
    .req (in_tvalid),
    .ptr (ptr),
    .win (win),
    .idx (win_idx),
    .any (any_req)
  );

  // grant is one-hot, so an OR-reduction mux is enough
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_1dw   = 1'b0;
    sel_data  = '0;
    for (int c = 0; c < N; c++) begin
      if (grant[c]) begin
        sel_valid = sel_valid | in_tvalid[c];
        sel_last  = sel_last  | in_tlast[c];
        sel_1dw   = sel_1dw   | in_1dw[c];
        sel_data  = sel_data  | in_tdata[c*W +: W];
      end
    end
  end

  assign busy      = (state == BUSY);
  assign can_load  = !tx_tvalid || tx_tready;
  assign in_tready = (busy && can_load) ? grant : '0;
  assign acc       = busy && can_load && sel_valid;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      gidx  <= '0;
      ptr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state <= BUSY;
            grant <= win;
            gidx  <= win_idx;
          end
        end
        BUSY: begin
          if (acc && sel_last) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= IW'(ring_add(int'(gidx), 1, N));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // output stage holds its fields while the core stalls
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tx_tvalid <= 1'b0;
      tx_tdata  <= '0;
      tx_tlast  <= 1'b0;
      tx_1dw    <= 1'b0;
    end else if (acc) begin
      tx_tvalid <= 1'b1;
      tx_tdata  <= sel_data;
      tx_tlast  <= sel_last;
      tx_1dw    <= sel_1dw;
    end else if (tx_tready) begin
      tx_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      pkt_count <= '0;
    end else if (tx_tvalid && tx_tready && tx_tlast) begin
      pkt_count <= pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hififo_tx_arb.sv
// Scoreboard bench for hififo_tx_arb: round-robin instance plus a
// fixed-priority instance sharing clock and reset.
module tb_hififo_tx_arb;

  localparam int N = 4;
  localparam int W = 64;

  typedef struct packed {
    logic [W-1:0] d;
    logic         last;
    logic         dw;
  } beat_t;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   in_tvalid;
  logic [N*W-1:0] in_tdata;
  logic [N-1:0]   in_tlast;
  logic [N-1:0]   in_1dw;
  logic [N-1:0]   in_tready;
  logic           tx_tvalid;
  logic [W-1:0]   tx_tdata;
  logic           tx_tlast;
  logic           tx_1dw;
  logic           tx_tready;
  logic [N-1:0]   grant;
  logic [31:0]    pkt_count;

  logic [N-1:0]   f_in_tvalid;
  logic [N*W-1:0] f_in_tdata;
  logic [N-1:0]   f_in_tlast;
  logic [N-1:0]   f_in_1dw;
  logic [N-1:0]   f_in_tready;
  logic           f_tx_tvalid;
  logic [W-1:0]   f_tx_tdata;
  logic           f_tx_tlast;
  logic           f_tx_1dw;
  logic           f_tx_tready;
  logic [N-1:0]   f_grant;
  logic [31:0]    f_pkt_count;

  always #5 clock = ~clock;

  hififo_tx_arb #(.N(N), .W(W), .FIXED_PRIO(0)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_tvalid (in_tvalid),
    .in_tdata  (in_tdata),
    .in_tlast  (in_tlast),
    .in_1dw    (in_1dw),
    .in_tready (in_tready),
    .tx_tvalid (tx_tvalid),
    .tx_tdata  (tx_tdata),
    .tx_tlast  (tx_tlast),
    .tx_1dw    (tx_1dw),
    .tx_tready (tx_tready),
    .grant     (grant),
    .pkt_count (pkt_count)
  );

  hififo_tx_arb #(.N(N), .W(W), .FIXED_PRIO(1)) dut_fp (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_tvalid (f_in_tvalid),
    .in_tdata  (f_in_tdata),
    .in_tlast  (f_in_tlast),
    .in_1dw    (f_in_1dw),
    .in_tready (f_in_tready),
    .tx_tvalid (f_tx_tvalid),
    .tx_tdata  (f_tx_tdata),
    .tx_tlast  (f_tx_tlast),
    .tx_1dw    (f_tx_1dw),
    .tx_tready (f_tx_tready),
    .grant     (f_grant),
    .pkt_count (f_pkt_count)
  );

  beat_t src_q[N][$];
  beat_t exp_q[$];
  logic  rdy_q[$];

  int checks   = 0;
  int failures = 0;

  logic         s_tvalid, s_tlast, s_1dw, s_tready;
  logic [W-1:0] s_tdata;
  logic [N-1:0] s_grant, s_in_tready;
  logic [31:0]  s_pkt;

  function automatic beat_t mk(input logic [W-1:0] d,
                               input logic last, input logic dw);
    beat_t r;
    r.d    = d;
    r.last = last;
    r.dw   = dw;
    return r;
  endfunction

  function automatic logic [W-1:0] enc(input int c, input int p,
                                       input int b);
    return W'(c * 65536 + p * 256 + b + 1);
  endfunction

  task automatic present();
    for (int c = 0; c < N; c++) begin
      if (src_q[c].size() > 0) begin
        in_tvalid[c]         = 1'b1;
        in_tdata[c*W +: W]   = src_q[c][0].d;
        in_tlast[c]          = src_q[c][0].last;
        in_1dw[c]            = src_q[c][0].dw;
      end else begin
        in_tvalid[c]         = 1'b0;
        in_tlast[c]          = 1'b0;
        in_1dw[c]            = 1'b0;
      end
    end
  endtask

  // one clock: sample + scoreboard at negedge, then advance sources
  task automatic step();
    logic [N-1:0] acc;
    beat_t        e;
    @(negedge clock);
    s_tvalid    = tx_tvalid;
    s_tdata     = tx_tdata;
    s_tlast     = tx_tlast;
    s_1dw       = tx_1dw;
    s_tready    = tx_tready;
    s_grant     = grant;
    s_in_tready = in_tready;
    s_pkt       = pkt_count;
    if (tx_tvalid && tx_tready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_extra got d=%h expected no beat", tx_tdata);
      end else begin
        e = exp_q.pop_front();
        if (tx_tdata !== e.d || tx_tlast !== e.last || tx_1dw !== e.dw) begin
          failures++;
          $display("FAIL sb_beat got d=%h l=%b dw=%b expected d=%h l=%b dw=%b",
                   tx_tdata, tx_tlast, tx_1dw, e.d, e.last, e.dw);
        end
      end
    end
    acc = in_tvalid & in_tready;
    @(posedge clock);
    #1;
    for (int c = 0; c < N; c++)
      if (acc[c] && src_q[c].size() > 0) void'(src_q[c].pop_front());
    present();
    tx_tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
  endtask

  task automatic clear_all();
    for (int c = 0; c < N; c++) src_q[c].delete();
    exp_q.delete();
    rdy_q.delete();
  endtask

  task automatic do_reset();
    clear_all();
    present();
    tx_tready = 1'b1;
    reset_n   = 1'b0;
    step();
    reset_n   = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain got %0d beats left expected 0", name,
               exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    step();
    checks++;
    if (s_tvalid !== 1'b0 || s_tdata !== '0 || s_tlast !== 1'b0 ||
        s_1dw !== 1'b0) begin
      failures++;
      $display("FAIL reset_tx got v=%b d=%h l=%b dw=%b expected all 0",
               s_tvalid, s_tdata, s_tlast, s_1dw);
    end
    checks++;
    if (s_grant !== '0 || s_in_tready !== '0 || s_pkt !== 32'd0) begin
      failures++;
      $display("FAIL reset_ctl got g=%b rdy=%b pkt=%0d expected 0 0 0",
               s_grant, s_in_tready, s_pkt);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] dv [3];
    dv[0] = 64'h11;
    dv[1] = 64'h22;
    dv[2] = 64'h33;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      src_q[0].push_back(mk(dv[b], b == 2, 1'b0));
      exp_q.push_back(mk(dv[b], b == 2, 1'b0));
    end
    present();
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) begin
        checks++;
        if (s_grant !== 4'b0000 || s_tvalid !== 1'b0) begin
          failures++;
          $display("FAIL basic_t0 got g=%b v=%b expected 0000 0",
                   s_grant, s_tvalid);
        end
      end
      if (k == 1) begin
        checks++;
        if (s_grant !== 4'b0001 || s_in_tready !== 4'b0001 ||
            s_tvalid !== 1'b0) begin
          failures++;
          $display("FAIL basic_t1 got g=%b rdy=%b v=%b expected 0001 0001 0",
                   s_grant, s_in_tready, s_tvalid);
        end
      end
      if (k >= 2 && k <= 4) begin
        checks++;
        if (s_tvalid !== 1'b1 || s_tdata !== dv[k-2] ||
            s_tlast !== (k == 4)) begin
          failures++;
          $display("FAIL basic_beat%0d got v=%b d=%h l=%b expected 1 %h %b",
                   k, s_tvalid, s_tdata, s_tlast, dv[k-2], k == 4);
        end
      end
      if (k == 5) begin
        checks++;
        if (s_tvalid !== 1'b0 || s_pkt !== 32'd1 || s_grant !== '0) begin
          failures++;
          $display("FAIL basic_end got v=%b pkt=%0d g=%b expected 0 1 0000",
                   s_tvalid, s_pkt, s_grant);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    int           ord_c [7];
    int           ord_p [7];
    int           nb;
    logic [N-1:0] glog [$];
    logic [N-1:0] prev_g;
    int           n;
    ord_c = '{0, 1, 2, 3, 0, 1, 2};
    ord_p = '{0, 0, 0, 0, 1, 1, 1};
    do_reset();
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 2; p++)
        for (int b = 0; b < 2; b++)
          src_q[c].push_back(mk(enc(c, p, b), b == 1, 1'b0));
    src_q[3].push_back(mk(enc(3, 0, 0), 1'b1, 1'b0));
    for (int i = 0; i < 7; i++) begin
      nb = (ord_c[i] == 3) ? 1 : 2;
      for (int b = 0; b < nb; b++)
        exp_q.push_back(mk(enc(ord_c[i], ord_p[i], b), b == nb - 1, 1'b0));
    end
    present();
    prev_g = '0;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      step();
      if (s_grant != '0 && prev_g == '0) glog.push_back(s_grant);
      prev_g = s_grant;
      n++;
    end
    checks++;
    if (glog.size() != 7) begin
      failures++;
      $display("FAIL rr_count got %0d grants expected 7", glog.size());
    end
    for (int i = 0; i < 7 && i < glog.size(); i++) begin
      checks++;
      if (glog[i] !== (4'b0001 << ord_c[i])) begin
        failures++;
        $display("FAIL rr_order[%0d] got %b expected %b", i, glog[i],
                 4'b0001 << ord_c[i]);
      end
    end
    drain("rr", 10);
  endtask

  task automatic test_fixed_prio();
    logic [31:0] p0;
    int          seen;
    f_in_tdata              = '0;
    f_in_tdata[1*W +: W]    = 64'hA1;
    f_in_tdata[3*W +: W]    = 64'hA3;
    f_in_tlast              = 4'b1111;
    f_in_1dw                = 4'b0000;
    f_tx_tready             = 1'b1;
    f_in_tvalid             = 4'b1010;
    @(negedge clock);
    p0   = f_pkt_count;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      checks++;
      if (f_grant[3] !== 1'b0) begin
        failures++;
        $display("FAIL fp_grant got %b expected ch3 never", f_grant);
      end
      if (f_tx_tvalid) begin
        seen++;
        checks++;
        if (f_tx_tdata !== 64'hA1) begin
          failures++;
          $display("FAIL fp_data got %h expected a1", f_tx_tdata);
        end
      end
    end
    checks++;
    if (f_pkt_count - p0 < 32'd9 || seen < 9) begin
      failures++;
      $display("FAIL fp_rate got %0d pkts expected >=9",
               f_pkt_count - p0);
    end
    f_in_tvalid = 4'b0000;
  endtask

  task automatic test_stall();
    logic         p_tvalid, p_tready, p_tlast;
    logic [W-1:0] p_tdata;
    int           stalls;
    int           n;
    do_reset();
    for (int b = 0; b < 4; b++) begin
      src_q[1].push_back(mk(enc(1, 0, b), b == 3, 1'b0));
      exp_q.push_back(mk(enc(1, 0, b), b == 3, 1'b0));
    end
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    present();
    p_tvalid = 1'b0;
    p_tready = 1'b1;
    p_tlast  = 1'b0;
    p_tdata  = '0;
    stalls   = 0;
    n        = 0;
    while (exp_q.size() > 0 && n < 40) begin
      step();
      if (p_tvalid && !p_tready) begin
        checks++;
        if (s_tvalid !== 1'b1 || s_tdata !== p_tdata ||
            s_tlast !== p_tlast) begin
          failures++;
          $display("FAIL stall_hold got v=%b d=%h l=%b expected 1 %h %b",
                   s_tvalid, s_tdata, s_tlast, p_tdata, p_tlast);
        end
      end
      if (s_tvalid && !s_tready) begin
        stalls++;
        checks++;
        if (s_in_tready !== '0) begin
          failures++;
          $display("FAIL stall_rdy got %b expected 0000", s_in_tready);
        end
      end
      p_tvalid = s_tvalid;
      p_tready = s_tready;
      p_tlast  = s_tlast;
      p_tdata  = s_tdata;
      n++;
    end
    checks++;
    if (stalls < 3) begin
      failures++;
      $display("FAIL stall_seen got %0d stalled cycles expected >=3", stalls);
    end
    drain("stall", 5);
    step();
    checks++;
    if (s_pkt !== 32'd1) begin
      failures++;
      $display("FAIL stall_pkt got %0d expected 1", s_pkt);
    end
  endtask

  task automatic test_reset_mid();
    for (int b = 0; b < 4; b++) begin
      src_q[0].push_back(mk(enc(0, 5, b), b == 3, 1'b0));
      exp_q.push_back(mk(enc(0, 5, b), b == 3, 1'b0));
    end
    present();
    step();
    step();
    step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    clear_all();
    present();
    step();
    checks++;
    if (s_tvalid !== 1'b0 || s_tdata !== '0 || s_tlast !== 1'b0 ||
        s_1dw !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_tx got v=%b d=%h l=%b dw=%b expected all 0",
               s_tvalid, s_tdata, s_tlast, s_1dw);
    end
    checks++;
    if (s_grant !== '0 || s_in_tready !== '0 || s_pkt !== 32'd0) begin
      failures++;
      $display("FAIL rstmid_ctl got g=%b rdy=%b pkt=%0d expected 0 0 0",
               s_grant, s_in_tready, s_pkt);
    end
    for (int b = 0; b < 3; b++) begin
      src_q[2].push_back(mk(enc(2, 0, b), b == 2, 1'b0));
      exp_q.push_back(mk(enc(2, 0, b), b == 2, 1'b0));
    end
    present();
    drain("rstmid", 20);
    step();
    checks++;
    if (s_pkt !== 32'd1) begin
      failures++;
      $display("FAIL rstmid_pkt got %0d expected 1", s_pkt);
    end
  endtask

  task automatic test_wrap_1dw();
    int n;
    do_reset();
    force dut.pkt_count = 32'hFFFF_FFFF;
    #1;
    release dut.pkt_count;
    for (int b = 0; b < 2; b++) begin
      src_q[3].push_back(mk(enc(3, 9, b), b == 1, 1'b1));
      exp_q.push_back(mk(enc(3, 9, b), b == 1, 1'b1));
    end
    present();
    step();
    checks++;
    if (s_pkt !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_pre got %h expected ffffffff", s_pkt);
    end
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin
      step();
      if (s_tvalid) begin
        checks++;
        if (s_1dw !== 1'b1) begin
          failures++;
          $display("FAIL dw_beat got %b expected 1", s_1dw);
        end
      end
      n++;
    end
    drain("wrap", 5);
    step();
    checks++;
    if (s_pkt !== 32'h0000_0000) begin
      failures++;
      $display("FAIL wrap_post got %h expected 00000000", s_pkt);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    in_tvalid   = '0;
    in_tdata    = '0;
    in_tlast    = '0;
    in_1dw      = '0;
    tx_tready   = 1'b1;
    f_in_tvalid = '0;
    f_in_tdata  = '0;
    f_in_tlast  = '0;
    f_in_1dw    = '0;
    f_tx_tready = 1'b1;
    test_reset();
    test_basic();
    test_round_robin();
    test_fixed_prio();
    test_stall();
    test_reset_mid();
    test_wrap_1dw();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hififo_tx_arb.md
# hififo_tx_arb

Parametrised N-channel packet arbiter that merges per-channel 64-bit AXI-stream TLP sources into the single TX stream feeding `pcie_core_wrap` (`s_axis_tx_*`). Whole packets are granted atomically, selected round-robin or fixed-priority, and passed through one registered output stage with full backpressure from the core. It replaces ad-hoc single-source TX muxing inside `hififo_pcie` as FIFO channel count grows.

## Interface
- `N`, 4: number of source channels (2..8).
- `W`, 64: data width in bits.
- `FIXED_PRIO`, 0: 0 = round-robin; 1 = lowest index wins.
- `clock`  in  1  single clock for all logic.
- `reset_n`  in  1  reset, synchronous, active-low.
- `in_tvalid`  in  N  per-channel beat valid.
- `in_tdata`  in  N*W  channel c at bits [c*W +: W].
- `in_tlast`  in  N  last beat of packet.
- `in_1dw`  in  N  packet is a 1-DW TLP (sampled per beat, forwarded).
- `in_tready`  out  N  per-channel accept.
- `tx_tvalid`  out  1  to core.
- `tx_tdata`  out  W  to core.
- `tx_tlast`  out  1  to core.
- `tx_1dw`  out  1  to core.
- `tx_tready`  in  1  from core.
- `grant`  out  N  one-hot current owner, 0 when idle.
- `pkt_count`  out  32  packets completed on tx (tlast && tvalid && tready), wraps.

## Operation
- Beat accepted on channel c when `in_tvalid[c] && in_tready[c]`; sources hold valid/data/last/1dw stable until accepted.
- `in_tready[c] = busy && grant[c] && (!tx_tvalid || tx_tready)`; all other channels' ready = 0.
- State machine, two states:
  - IDLE: `grant` = 0. If any `in_tvalid`, pick winner, load `grant`, go BUSY next cycle. No requester: stay.
  - BUSY: forward granted channel beats into output register. On accepted beat with `in_tlast`: go IDLE, clear `grant`; round-robin pointer := winner+1 mod N.
- Round-robin pick: first requesting channel at or after pointer, scanning upward with wrap. Fixed-priority: lowest requesting index; pointer ignored.
- Output register: loads on input accept; `tx_tvalid` clears when `tx_tready` and no new load the same cycle. `tx_tvalid` never drops and tx fields never change while `tx_tvalid && !tx_tready`.
- Channel whose `in_tvalid` drops mid-packet keeps grant (bubbles allowed); no other channel interleaves until its tlast.
- `pkt_count` increments by 1 on each output-side tlast handshake; 32-bit wrap 0xFFFFFFFF -> 0.
- Reset (`reset_n` low at clock edge), including mid-packet: state IDLE, `grant` 0, pointer 0, `tx_tvalid` 0, `tx_tlast` 0, `tx_1dw` 0, `tx_tdata` 0, `pkt_count` 0, all `in_tready` 0. Partial packet is discarded; recovery of the source is the source's responsibility.

## Timing
- Arbitration latency: request in IDLE at cycle t -> `grant` valid t+1 -> first `in_tready` t+1 -> `tx_tvalid` t+2.
- Input-to-output latency: 1 cycle per beat.
- Throughput inside a packet: 1 beat/cycle while `tx_tready` held high.
- Inter-packet gap: exactly 1 idle cycle on input side (IDLE state) between consecutive packets, any channel.
- Single-beat packet (tvalid and tlast together): grant held exactly one BUSY cycle when accepted immediately.
- `in_tready` is combinational from `tx_tready` and registered state; no combinational path from `in_tvalid` to `in_tready`.

## Structure
- Package `hififo_pkg`: state enum (IDLE, BUSY), default `W`, max `N`, `pkt_count` width.
- Sub-module `hififo_rr_pick`: combinational one-hot picker (request vector, pointer, `FIXED_PRIO`) -> winner one-hot and index; reused by future RX demux/interrupt arbiters.

## Test plan
- Single channel 0, 3-beat packet 0x11,0x22,0x33, `tx_tready`=1 -> tx shows 0x11..0x33 on cycles t+2..t+4, tlast on 0x33, `pkt_count`=1.
- Channels 0,1,2 each request continuously, round-robin -> grant order 0,1,2,0; pointer wrap from N-1 to 0 verified with N=4, channel 3 requesting.
- `FIXED_PRIO`=1, channels 1 and 3 always requesting -> channel 1 wins every packet; channel 3 starved.
- `tx_tready` toggled 1,0,0,1 during 4-beat packet -> tx fields stable while stalled, no beat lost or duplicated, `in_tready` 0 during stall.
- `reset_n` low for one cycle mid-packet (beat 2 of 4) -> next cycle all outputs at reset values, `pkt_count`=0; new packet from channel 2 then completes normally.
- `pkt_count` preloaded via force to 0xFFFFFFFF, one packet sent -> 0x00000000; `in_1dw`=1 packet -> `tx_1dw`=1 on every output beat.
